// File: rtl/iobus_uart_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : iobus_uart_tx                                                   |
// | Purpose  : OTTER IOBUS MMIO UART transmitter. Stores to DATA push a byte   |
// |            into a TX FIFO; bytes are serialised LSB first as 8N1 (or 8E1). |
// |            STATUS is readable at BASE_AD+4 and clears OVF when written.    |
// | Options  : UART_TX_PARITY_EN - inserts an even-parity bit before the stop  |
// |            bit.                                                            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module iobus_uart_tx #(
  parameter logic [31:0] BASE_AD    = 32'h1118_0000,
  parameter int          CLK_HZ     = 50_000_000,
  parameter int          BAUD       = 115200,
  parameter int          FIFO_DEPTH = 16
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic [31:0] IOBUS_ADDR,
  input  logic [31:0] IOBUS_OUT,
  input  logic        IOBUS_WR,
  output logic [31:0] RD_DATA,
  output logic        TX,
  output logic        TX_IRQ
);

  localparam int              c_DIV       = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int              c_BW        = (c_DIV > 1) ? $clog2(c_DIV) : 1;
  localparam int              c_PW        = $clog2(FIFO_DEPTH);
  localparam int              c_CW        = c_PW + 1;
  localparam logic [c_BW-1:0] c_BAUD_LAST = c_BW'(c_DIV - 1);
  localparam logic [c_CW-1:0] c_FULL      = c_CW'(FIFO_DEPTH);
  localparam logic [31:0]     c_STAT_AD   = BASE_AD + 32'd4;

  localparam logic [2:0] c_S_IDLE   = 3'd0;
  localparam logic [2:0] c_S_START  = 3'd1;
  localparam logic [2:0] c_S_DATA   = 3'd2;
  localparam logic [2:0] c_S_STOP   = 3'd4;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] c_S_PARITY = 3'd3;
`endif

  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [c_PW-1:0] r_wr_ptr;
  logic [c_PW-1:0] r_rd_ptr;
  logic [c_CW-1:0] r_count;
  logic            r_ovf;
  logic [2:0]      r_state;
  logic [2:0]      w_next_state;
  logic [7:0]      r_shift;
  logic [c_BW-1:0] r_baud;
  logic [2:0]      r_bitn;
  logic            r_tx;
  logic            r_irq;
`ifdef UART_TX_PARITY_EN
  logic            r_parity;
`endif

  logic        w_wr_data;
  logic        w_wr_stat;
  logic        w_empty;
  logic        w_full;
  logic        w_busy;
  logic        w_bit_end;
  logic        w_last_bit;
  logic        w_pop;
  logic        w_push;
  logic        w_tx_next;
  logic        w_irq_next;
  logic [31:0] w_status;
  logic        w_unused_bits;

  assign w_wr_data     = IOBUS_WR && (IOBUS_ADDR == BASE_AD);
  assign w_wr_stat     = IOBUS_WR && (IOBUS_ADDR == c_STAT_AD);
  assign w_empty       = (r_count == '0);
  assign w_full        = (r_count == c_FULL);
  assign w_busy        = (r_state != c_S_IDLE);
  assign w_bit_end     = (r_baud == c_BAUD_LAST);
  assign w_last_bit    = (r_bitn == 3'd7);
  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign w_push        = w_wr_data && (!w_full || w_pop);
  assign w_unused_bits = ^{IOBUS_OUT[31:12], IOBUS_OUT[10:8]};

  // STATUS image and read mux; reads never change state
  always_comb begin
    w_status              = '0;
    w_status[c_CW-1:0]    = r_count;
    w_status[8]           = w_busy;
    w_status[9]           = w_empty;
    w_status[10]          = w_full;
    w_status[11]          = r_ovf;
    RD_DATA               = (IOBUS_ADDR == c_STAT_AD) ? w_status : 32'h0;
  end

  // FIFO storage; contents need no reset because count gates every read
  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wr_ptr] <= IOBUS_OUT[7:0];
  end

  // FIFO pointers, occupancy and sticky overflow flag
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CW'(1);
        2'b01:   r_count <= r_count - c_CW'(1);
        default: r_count <= r_count;
      endcase
      // A dropped byte wins over a clear request in the same cycle.
      if (w_wr_data && !w_push)              r_ovf <= 1'b1;
      else if (w_wr_stat && IOBUS_OUT[11])   r_ovf <= 1'b0;
    end
  end

  // FSM state register
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) r_state <= c_S_IDLE;
    else          r_state <= w_next_state;
  end

  // FSM next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_S_IDLE:   if (!w_empty) w_next_state = c_S_START;
      c_S_START:  if (w_bit_end) w_next_state = c_S_DATA;
      c_S_DATA:   if (w_bit_end && w_last_bit)
`ifdef UART_TX_PARITY_EN
                    w_next_state = c_S_PARITY;
      c_S_PARITY: if (w_bit_end) w_next_state = c_S_STOP;
`else
                    w_next_state = c_S_STOP;
`endif
      c_S_STOP:   if (w_bit_end) w_next_state = w_empty ? c_S_IDLE : c_S_START;
      default:    w_next_state = c_S_IDLE;
    endcase
  end

  // FSM outputs: FIFO pop, next line level and end-of-burst interrupt
  always_comb begin
    w_pop      = 1'b0;
    w_tx_next  = r_tx;
    w_irq_next = 1'b0;
    case (r_state)
      c_S_IDLE: begin
        w_pop     = !w_empty;
        w_tx_next = w_empty;
      end
      c_S_START:  if (w_bit_end) w_tx_next = r_shift[0];
      c_S_DATA: begin
        if (w_bit_end) begin
          if (w_last_bit)
`ifdef UART_TX_PARITY_EN
            w_tx_next = r_parity;
`else
            w_tx_next = 1'b1;
`endif
          else
            w_tx_next = r_shift[1];
        end
      end
`ifdef UART_TX_PARITY_EN
      c_S_PARITY: if (w_bit_end) w_tx_next = 1'b1;
`endif
      c_S_STOP: begin
        if (w_bit_end) begin
          // Back-to-back frames go straight from stop to start.
          w_pop      = !w_empty;
          w_tx_next  = w_empty;
          w_irq_next = w_empty;
        end
      end
      default:    w_tx_next = 1'b1;
    endcase
  end

  // Transmit datapath: baud timer, bit counter, shifter and registered line
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_shift  <= '0;
      r_baud   <= '0;
      r_bitn   <= '0;
      r_tx     <= 1'b1;
      r_irq    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_parity <= 1'b0;
`endif
    end else begin
      r_tx  <= w_tx_next;
      r_irq <= w_irq_next;
      if (w_pop) begin
        r_shift  <= r_mem[r_rd_ptr];
        r_baud   <= '0;
        r_bitn   <= '0;
`ifdef UART_TX_PARITY_EN
        r_parity <= ^r_mem[r_rd_ptr];
`endif
      end else if (w_busy) begin
        r_baud <= w_bit_end ? '0 : r_baud + c_BW'(1);
        if (w_bit_end && (r_state == c_S_DATA)) begin
          r_shift <= {1'b0, r_shift[7:1]};
          r_bitn  <= r_bitn + 3'd1;
        end
      end
    end
  end

  assign TX     = r_tx;
  assign TX_IRQ = r_irq;

endmodule
`default_nettype wire
